tile_scheduler: RTL
===================

# tile_scheduler

Sequences the MAC_SIZE×MAC_SIZE systolic accelerator core over a BIG_MAC_SIZE×BIG_MAC_SIZE matrix multiply C = A·B. It walks the tile indices (ti, tj, tk), computes per-tile word base addresses for the input and output controllers, and drives the core's comp_enb/done handshake once per tile. It raises a single completion pulse when all tiles are finished. It sits between the host/top-level start logic and the accelerator core.

## Interface
- BIG_MAC_SIZE, 512, full matrix dimension N; must be a multiple of MAC_SIZE
- MAC_SIZE, 64, core array dimension (tile edge)
- ADDR_WIDTH, 23, memory word-address width
- SETUP_CYCLES, 2, cycles core_comp_enb is held high before each tile (≥1)
- TIMEOUT_CYCLES, 1048576, RUN-state cycle limit (used only with TILE_SCHED_TIMEOUT_EN)
- clk  input  1  clock, all logic on rising edge
- reset_b  input  1  synchronous active-low reset
- start  input  1  single-cycle request to begin a job
- a_base, b_base, c_base  input  ADDR_WIDTH each  word base addresses of A, B, C; latched on accepted start
- core_done  input  1  core finished current tile
- core_comp_enb  output  1  high = core held in reset/load, low = core runs
- acc_first  output  1  current tile has tk==0 (core clears accumulators)
- acc_last  output  1  current tile has tk==T-1 (core writes results)
- tile_a_addr, tile_b_addr, tile_c_addr  output  ADDR_WIDTH each  current tile word bases
- busyb  output  1  low while a job is active
- done  output  1  one-cycle pulse at job completion
- err  output  1  sticky timeout flag

## Operation
- T = BIG_MAC_SIZE/MAC_SIZE; job = T³ tiles; loop order ti (outer), tj, tk (inner).
- A/B: 8 elements per 64-bit word; C: 2 elements per word (32-bit slots).
- tile_a_addr = a_base + ti·MAC_SIZE·N/8 + tk·MAC_SIZE/8; tile_b_addr = b_base + tk·MAC_SIZE·N/8 + tj·MAC_SIZE/8; tile_c_addr = c_base + ti·MAC_SIZE·N/2 + tj·MAC_SIZE/2. All modulo 2^ADDR_WIDTH (wrap silently).
- States: IDLE → SETUP → RUN → ADVANCE → SETUP … → FINISH → IDLE; ERROR only with timeout feature.
- IDLE: core_comp_enb=1, busyb=1; start=1 latches bases, clears indices → SETUP.
- SETUP: core_comp_enb=1 for exactly SETUP_CYCLES cycles → RUN.
- RUN: core_comp_enb=0; core_done=1 → ADVANCE, or FINISH if last tile (ti=tj=tk=T-1).
- ADVANCE (1 cycle): core_comp_enb=1; increment tk, carry into tj, then ti → SETUP.
- FINISH (1 cycle): done=1, busyb=1, core_comp_enb=1 → IDLE.
- start outside IDLE ignored; core_done outside RUN ignored.
- Reset (any state, any cycle): all outputs to reset values next edge, state IDLE.

## Timing
- Reset values: core_comp_enb=1, busyb=1, done=0, err=0, acc_first=0, acc_last=0, all addresses 0.
- start sampled at edge E → at E+1: state SETUP, busyb=0, addresses/acc flags valid for tile 0.
- Addresses and acc flags registered; stable from first SETUP cycle through end of RUN.
- core_comp_enb falls SETUP_CYCLES cycles after SETUP entry.
- core_done sampled in RUN at edge E → ADVANCE/FINISH at E+1.
- Per-tile overhead outside RUN: SETUP_CYCLES + 1 cycles.
- done pulse exactly one cycle; start in FINISH cycle ignored, accepted next cycle in IDLE.

## Configuration
- TILE_SCHED_TIMEOUT_EN defined: RUN counter cleared on RUN entry; if reaches TIMEOUT_CYCLES without core_done → ERROR: err=1, core_comp_enb=1, busyb=1, done never pulses; ERROR exits to IDLE only via reset_b=0 or start=1 (which clears err and begins a new job). core_done on the same edge as expiry wins (normal advance).
- Undefined: no counter, RUN waits indefinitely, err tied 0.

## Test plan
- Reset: drive reset_b=0 mid-RUN → next cycle core_comp_enb=1, busyb=1, done=0, addresses 0, state IDLE.
- Full job, N=16, MAC=8, SETUP_CYCLES=2, bases 0, core_done 3 cycles after each comp_enb fall → 8 tiles, acc_first on tiles 0,2,4,6, acc_last on 1,3,5,7, one done pulse.
- Address check, same config, c_base=0x100: tile (ti=1,tj=1,tk=1) → tile_a_addr=17, tile_b_addr=17, tile_c_addr=0x100+68=0x144.
- Wrap: ADDR_WIDTH=8, a_base=0xF8, tile (1,·,1) → tile_a_addr=(0xF8+17) mod 256=0x09.
- Spurious events: start pulsed in RUN and core_done pulsed in SETUP → no restart, no index advance, tile count still 8.
- With TILE_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=10, core_done never asserted → err=1 after 10 RUN cycles, busyb=1, no done; start → err=0, new job begins.

Source files
------------

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks (ti, tj, tk) tiles of a BIG_MAC_SIZE^2 matmul over a
// MAC_SIZE^2 systolic core, issuing per-tile word bases and the core's
// comp_enb/done handshake, with a one-cycle done pulse at job end.
// Optional build macro: TILE_SCHED_TIMEOUT_EN adds a RUN-state watchdog that
// parks the block in ERROR with a sticky err flag.
module tile_scheduler #(
  parameter int BIG_MAC_SIZE   = 512,
  parameter int MAC_SIZE       = 64,
  parameter int ADDR_WIDTH     = 23,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] c_base,
  input  logic                  core_done,
  output logic                  core_comp_enb,
  output logic                  acc_first,
  output logic                  acc_last,
  output logic [ADDR_WIDTH-1:0] tile_a_addr,
  output logic [ADDR_WIDTH-1:0] tile_b_addr,
  output logic [ADDR_WIDTH-1:0] tile_c_addr,
  output logic                  busyb,
  output logic                  done,
  output logic                  err
);

  localparam int T       = BIG_MAC_SIZE / MAC_SIZE;
  localparam int IDX_W   = (T > 1) ? $clog2(T) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(T - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);

  // Word strides: A/B pack 8 elements per word, C packs 2.
  localparam logic [ADDR_WIDTH-1:0] AB_ROW = ADDR_WIDTH'(MAC_SIZE * BIG_MAC_SIZE / 8);
  localparam logic [ADDR_WIDTH-1:0] AB_COL = ADDR_WIDTH'(MAC_SIZE / 8);
  localparam logic [ADDR_WIDTH-1:0] C_ROW  = ADDR_WIDTH'(MAC_SIZE * BIG_MAC_SIZE / 2);
  localparam logic [ADDR_WIDTH-1:0] C_COL  = ADDR_WIDTH'(MAC_SIZE / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RUN, S_ADVANCE, S_FINISH, S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      ti_q, ti_d, tj_q, tj_d, tk_q, tk_d;
  logic [ADDR_WIDTH-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic                  first_q, last_q;
  logic                  load_tile;
  logic                  last_tile;

`ifdef TILE_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic err_q, err_d;
`endif

  assign last_tile = (ti_q == LAST_IDX) && (tj_q == LAST_IDX) && (tk_q == LAST_IDX);

  // Next-state, index walk and tile-load strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ti_d      = ti_q;
    tj_d      = tj_q;
    tk_d      = tk_q;
    a_base_d  = a_base_q;
    b_base_d  = b_base_q;
    c_base_d  = c_base_q;
    load_tile = 1'b0;
`ifdef TILE_SCHED_TIMEOUT_EN
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          a_base_d  = a_base;
          b_base_d  = b_base;
          c_base_d  = c_base;
          ti_d      = '0;
          tj_d      = '0;
          tk_d      = '0;
          cnt_d     = '0;
          load_tile = 1'b1;
          state_d   = S_SETUP;
`ifdef TILE_SCHED_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // core_done takes priority over a coincident watchdog expiry.
        if (core_done) begin
          state_d = last_tile ? S_FINISH : S_ADVANCE;
        end
`ifdef TILE_SCHED_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_ADVANCE: begin
        if (tk_q == LAST_IDX) begin
          tk_d = '0;
          if (tj_q == LAST_IDX) begin
            tj_d = '0;
            ti_d = ti_q + 1'b1;
          end else begin
            tj_d = tj_q + 1'b1;
          end
        end else begin
          tk_d = tk_q + 1'b1;
        end
        cnt_d     = '0;
        load_tile = 1'b1;
        state_d   = S_SETUP;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Tile bases derived from the next indices so they land with SETUP entry.
  always_comb begin
    a_addr_d = a_base_d + ADDR_WIDTH'(ti_d) * AB_ROW + ADDR_WIDTH'(tk_d) * AB_COL;
    b_addr_d = b_base_d + ADDR_WIDTH'(tk_d) * AB_ROW + ADDR_WIDTH'(tj_d) * AB_COL;
    c_addr_d = c_base_d + ADDR_WIDTH'(ti_d) * C_ROW  + ADDR_WIDTH'(tj_d) * C_COL;
  end

  // State, counters, latched bases and per-tile outputs.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ti_q     <= '0;
      tj_q     <= '0;
      tk_q     <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ti_q     <= ti_d;
      tj_q     <= tj_d;
      tk_q     <= tk_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      if (load_tile) begin
        a_addr_q <= a_addr_d;
        b_addr_q <= b_addr_d;
        c_addr_q <= c_addr_d;
        first_q  <= (tk_d == '0);
        last_q   <= (tk_d == LAST_IDX);
      end
    end
  end

`ifdef TILE_SCHED_TIMEOUT_EN
  // Sticky watchdog flag, cleared by reset or a new start.
  always_ff @(posedge clk) begin
    if (!reset_b) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign core_comp_enb = (state_q != S_RUN);
  assign busyb         = (state_q == S_IDLE) || (state_q == S_FINISH) || (state_q == S_ERROR);
  assign done          = (state_q == S_FINISH);
  assign acc_first     = first_q;
  assign acc_last      = last_q;
  assign tile_a_addr   = a_addr_q;
  assign tile_b_addr   = b_addr_q;
  assign tile_c_addr   = c_addr_q;

endmodule
